// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-file parameters and types for the scoreboard, the register
// file and the hazard/forwarding units.
package regfile_scoreboard_pkg;

  localparam int NUM_REGS    = 32;
  localparam int ADDR_W      = 5;
  localparam int CNT_W       = 2;
  localparam int STALL_CNT_W = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : regfile_scoreboard_pkg

// File: rtl/regfile_scoreboard_sb_counter.sv
// One per-register in-flight write counter. A decrement is ignored at zero;
// an increment paired with an effective decrement leaves the count unchanged.
module sb_counter #(
  parameter int CNT_W = regfile_scoreboard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max,
  output logic             is_zero
);

  logic do_dec;

  assign at_max  = &cnt;
  assign is_zero = ~|cnt;
  assign do_dec  = dec & ~is_zero;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc && !do_dec && !at_max) begin
      cnt <= cnt + 1'b1;
    end else if (do_dec && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule : sb_counter

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: counts in-flight writes per register and stalls ID
// on RAW hazards or a saturated destination counter, with debug visibility.
module regfile_scoreboard #(
  parameter int NUM_REGS    = regfile_scoreboard_pkg::NUM_REGS,
  parameter int ADDR_W      = regfile_scoreboard_pkg::ADDR_W,
  parameter int CNT_W       = regfile_scoreboard_pkg::CNT_W,
  parameter int STALL_CNT_W = regfile_scoreboard_pkg::STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic                   issue_regwrite,
  input  logic [ADDR_W-1:0]      issue_rd,
  input  logic [ADDR_W-1:0]      rs1,
  input  logic [ADDR_W-1:0]      rs2,
  input  logic                   rs1_used,
  input  logic                   rs2_used,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_rd,
  output logic                   stall,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   underflow_err
);

  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] at_max;
  logic [NUM_REGS-1:0] is_zero;
  logic [CNT_W-1:0]    cnt [NUM_REGS];

  logic haz_rs1;
  logic haz_rs2;
  logic haz_ovf;
  logic accept;
  logic underflow;

  // x0 has no counter: permanently idle and never saturated.
  assign cnt[0]     = '0;
  assign at_max[0]  = 1'b0;
  assign is_zero[0] = 1'b1;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc[i]),
      .dec     (dec[i]),
      .cnt     (cnt[i]),
      .at_max  (at_max[i]),
      .is_zero (is_zero[i])
    );
  end

  // A final writeback in the same cycle satisfies the read, since the
  // register file writes on the falling edge.
  always_comb begin
    haz_rs1 = rs1_used && (rs1 != '0) && !is_zero[rs1] &&
              !(wb_valid && (wb_rd == rs1) && (cnt[rs1] == CNT_W'(1)));
    haz_rs2 = rs2_used && (rs2 != '0) && !is_zero[rs2] &&
              !(wb_valid && (wb_rd == rs2) && (cnt[rs2] == CNT_W'(1)));
    haz_ovf = issue_regwrite && (issue_rd != '0) && at_max[issue_rd] &&
              !(wb_valid && (wb_rd == issue_rd));
  end

  assign stall     = issue_valid & (haz_rs1 | haz_rs2 | haz_ovf);
  assign accept    = issue_valid & ~stall;
  assign underflow = wb_valid && (wb_rd != '0) && is_zero[wb_rd];

  // NOTE: every bit written in always_comb gets a default first, so no path
  // leaves a bit unassigned and no latch is inferred.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc[i] = accept && issue_regwrite && (issue_rd == ADDR_W'(i));
      dec[i] = wb_valid && (wb_rd == ADDR_W'(i));
    end
  end

  assign busy_mask = ~is_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count   <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (stall && !(&stall_count)) begin
        stall_count <= stall_count + 1'b1;
      end
      if (underflow) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, reset
// corner sequence, and randomized traffic against a counting reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_regwrite;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        rs1_used, rs2_used;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] busy_mask;
  logic [15:0] stall_count;
  logic        underflow_err;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_rd       (issue_rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .rs1_used       (rs1_used),
    .rs2_used       (rs2_used),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .stall          (stall),
    .busy_mask      (busy_mask),
    .stall_count    (stall_count),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv, rw;
    logic [4:0]  rd, s1, s2;
    logic        u1, u2, wv;
    logic [4:0]  wrd;
    logic        e_stall;
    logic [31:0] e_busy;
    logic [15:0] e_sc;
    logic        e_err;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic iv, input logic rw, input int rd,
                              input int s1, input int s2, input logic u1,
                              input logic u2, input logic wv, input int wrd,
                              input logic es, input int eb, input int esc,
                              input logic ee);
    vec_t v;
    v.iv = iv; v.rw = rw; v.rd = 5'(rd); v.s1 = 5'(s1); v.s2 = 5'(s2);
    v.u1 = u1; v.u2 = u2; v.wv = wv; v.wrd = 5'(wrd);
    v.e_stall = es; v.e_busy = 32'(eb); v.e_sc = 16'(esc); v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; issue_regwrite = v.rw; issue_rd = v.rd;
    rs1 = v.s1; rs2 = v.s2; rs1_used = v.u1; rs2_used = v.u2;
    wb_valid = v.wv; wb_rd = v.wrd;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain per-register outstanding-write counts.
  int m_cnt [32];
  int m_sc;
  bit m_err;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 'h20, 0, 0);
    tbl[1]  = mk(1, 1, 6, 5, 0, 1, 0, 0, 0, 1, 'h20, 1, 0);
    tbl[2]  = mk(1, 1, 6, 5, 0, 1, 0, 0, 0, 1, 'h20, 2, 0);
    tbl[3]  = mk(1, 1, 6, 5, 0, 1, 0, 1, 5, 0, 'h40, 2, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 'h00, 2, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 'h00, 2, 0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 'h00, 2, 0);
    tbl[7]  = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 'h80, 2, 0);
    tbl[8]  = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 'h80, 2, 0);
    tbl[9]  = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 'h80, 2, 0);
    tbl[10] = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 'h80, 3, 0);
    tbl[11] = mk(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 'h80, 3, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 'h80, 3, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h80, 3, 1);
    tbl[14] = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 'h88, 3, 1);
    tbl[15] = mk(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 'h88, 3, 1);
    tbl[16] = mk(1, 0, 0, 0, 3, 0, 1, 0, 0, 1, 'h88, 4, 1);
    tbl[17] = mk(1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 'h88, 4, 1);
    tbl[18] = mk(1, 0, 0, 7, 0, 1, 0, 1, 7, 1, 'h88, 5, 1);

    idle();
    reset = 1'b0;
    #12;
    check("reset busy_mask", 64'(busy_mask), 64'(0));
    check("reset stall_count", 64'(stall_count), 64'(0));
    check("reset underflow_err", 64'(underflow_err), 64'(0));
    check("reset stall", 64'(stall), 64'(0));
    do_reset();

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("tbl%0d stall", i), 64'(stall), 64'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d busy_mask", i), 64'(busy_mask), 64'(tbl[i].e_busy));
      check($sformatf("tbl%0d stall_count", i), 64'(stall_count), 64'(tbl[i].e_sc));
      check($sformatf("tbl%0d underflow_err", i), 64'(underflow_err), 64'(tbl[i].e_err));
    end

    // Async reset mid-run with cnt[5] = 2 and a pending stall.
    do_reset();
    drive(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) begin @(posedge clk); #1; end
    check("pre-reset busy_mask", 64'(busy_mask), 64'h20);
    drive(mk(1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("pre-reset stall_count", 64'(stall_count), 64'(1));
    #1;
    check("pre-reset stall", 64'(stall), 64'(1));
    reset = 1'b0;
    #1;
    check("async reset busy_mask", 64'(busy_mask), 64'(0));
    check("async reset stall", 64'(stall), 64'(0));
    check("async reset stall_count", 64'(stall_count), 64'(0));
    check("async reset underflow_err", 64'(underflow_err), 64'(0));
    idle();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0));
    @(posedge clk); #1;
    check("stale wb underflow_err", 64'(underflow_err), 64'(1));
    check("stale wb busy_mask", 64'(busy_mask), 64'(0));

    // Randomized traffic against the reference model.
    do_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_sc = 0;
    m_err = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit hz1, hz2, ovf, exp_stall, acc;
      logic [31:0] exp_busy;
      issue_valid    = ($urandom_range(3) != 0);
      issue_regwrite = $urandom_range(1);
      issue_rd       = 5'($urandom_range(7));
      rs1            = 5'($urandom_range(7));
      rs2            = 5'($urandom_range(7));
      rs1_used       = $urandom_range(1);
      rs2_used       = $urandom_range(1);
      wb_rd          = 5'($urandom_range(7));
      wb_valid       = ($urandom_range(1) == 1) &&
                       (m_cnt[wb_rd] != 0 || $urandom_range(31) == 0);

      hz1 = rs1_used && rs1 != 0 && m_cnt[rs1] > 0 &&
            !(wb_valid && wb_rd == rs1 && m_cnt[rs1] == 1);
      hz2 = rs2_used && rs2 != 0 && m_cnt[rs2] > 0 &&
            !(wb_valid && wb_rd == rs2 && m_cnt[rs2] == 1);
      ovf = issue_regwrite && issue_rd != 0 && m_cnt[issue_rd] == 3 &&
            !(wb_valid && wb_rd == issue_rd);
      exp_stall = issue_valid && (hz1 || hz2 || ovf);
      acc = issue_valid && !exp_stall;
      #1;
      check($sformatf("rand%0d stall", cyc), 64'(stall), 64'(exp_stall));

      begin
        int inc_r, dec_r;
        inc_r = (acc && issue_regwrite && issue_rd != 0) ? int'(issue_rd) : -1;
        dec_r = -1;
        if (wb_valid && wb_rd != 0) begin
          if (m_cnt[wb_rd] > 0) dec_r = int'(wb_rd);
          else m_err = 1;
        end
        if (inc_r >= 0) m_cnt[inc_r]++;
        if (dec_r >= 0) m_cnt[dec_r]--;
      end
      if (exp_stall && m_sc < 65535) m_sc++;
      exp_busy = '0;
      for (int r = 1; r < 32; r++) exp_busy[r] = (m_cnt[r] != 0);

      @(posedge clk); #1;
      check($sformatf("rand%0d busy_mask", cyc), 64'(busy_mask), 64'(exp_busy));
      check($sformatf("rand%0d stall_count", cyc), 64'(stall_count), 64'(m_sc));
      check($sformatf("rand%0d underflow_err", cyc), 64'(underflow_err), 64'(m_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_scoreboard
